// File: rtl/apb_bridge_controller.sv
// APB master sequencer for the AHB-to-APB bridge: decodes the slave from the address,
// runs SETUP/ACCESS with wait states, and returns OKAY or a two-cycle AHB ERROR.
module apb_bridge_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 16
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic                  Hwrite,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    output logic                  Hreadyout,
    output logic                  Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [NUM_SLAVES-1:0] Psel,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata,
    input  logic [DATA_WIDTH-1:0] Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0]   NUM_SLAVES_W = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [CNT_W-1:0] CNT_LAST     = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                r_state;
    logic [SEL_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                  w_ready_state;
    logic                  w_sel_active;
    logic [SEL_W-1:0]      w_haddr_idx;
    logic                  w_decode_err;
    logic                  w_timeout;

    assign w_ready_state = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_sel_active  = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_haddr_idx   = Haddr[SEL_LSB +: SEL_W];
    assign w_decode_err  = ({1'b0, w_haddr_idx} >= NUM_SLAVES_W);
    // The counter holds the number of ACCESS cycles already spent waiting.
    assign w_timeout     = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST) && !Pready;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_hrdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR2: begin
                    if (valid) begin
                        r_paddr  <= Haddr;
                        r_pwrite <= Hwrite;
                        r_idx    <= w_haddr_idx;
                        if (w_decode_err)
                            r_state <= S_ERR1;
                        else if (Hwrite)
                            r_state <= S_WWAIT;
                        else
                            r_state <= S_SETUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WWAIT: begin
                    r_pwdata <= Hwdata;
                    r_state  <= S_SETUP;
                end
                S_SETUP: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (Pready) begin
                        if (Pslverr) begin
                            r_state <= S_ERR1;
                        end else begin
                            if (!r_pwrite)
                                r_hrdata <= Prdata;
                            r_state <= S_DONE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR1;
                    end else if (r_wait_cnt != CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_ERR1:  r_state <= S_ERR2;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Hreadyout = w_ready_state;
    assign Hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign Penable   = (r_state == S_ACCESS);
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Hrdata    = r_hrdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
            assign Psel[gi] = w_sel_active && (r_idx == SEL_W'(gi));
        end
    endgenerate

endmodule
